pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, giving the consecutive memory-wait cycles before a timeout is flagged.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port IDEX_MemRead, input, 1 bit: the instruction in ID/EX is a load.
REQ-006 SHALL have port IDEX_Rt, input, 5 bits: the load destination register in ID/EX.
REQ-007 SHALL have ports IFID_Rs and IFID_Rt, inputs, 5 bits each: the source registers of the instruction in IF/ID.
REQ-008 SHALL have port IFID_UsesRt, input, 1 bit: the IF/ID instruction reads Rt.
REQ-009 SHALL have port BranchTaken, input, 1 bit: a branch or jump resolved taken this cycle.
REQ-010 SHALL have ports MemReq and MemReady, inputs, 1 bit each: the MEM stage accesses data memory, and that memory completes this cycle.
REQ-011 SHALL have ports PCWrite, IFIDEn, IDEXEn, EXMEMEn and MEMWBEn, outputs, 1 bit each: write enables for the PC and the pipeline registers.
REQ-012 SHALL have ports IFIDFlush, IDEXFlush and MEMWBFlush, outputs, 1 bit each: synchronous bubble inserts into the named pipeline registers.
REQ-013 SHALL have port StallCount, output, CNT_W bits: the number of cycles with PCWrite=0.
REQ-014 SHALL have port MemTimeout, output, 1 bit: sticky memory-timeout error.
REQ-015 SHALL have port State, output, 2 bits: the FSM state encoding.

Function
REQ-016 SHALL define the load-use hazard LU = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & (IDEX_Rt==IFID_Rt))).
REQ-017 SHALL define the memory wait MW = MemReq & ~MemReady.
REQ-018 SHALL implement FSM states RUN=00, LU_STALL=01 and MEM_WAIT=10; encoding 11 is unreachable and SHALL behave as RUN, with next state RUN.
REQ-019 SHALL make the outputs combinational (Mealy) from State and the current inputs.
REQ-020 SHALL, with no event active, drive all enables to 1 and all flushes to 0 (the "normal" outputs).
REQ-021 SHALL, in RUN or on the MEM_WAIT release cycle, evaluate events in the priority MW > BranchTaken > LU.
REQ-022 SHALL, on MW, drive PCWrite=IFIDEn=IDEXEn=EXMEMEn=0, MEMWBEn=1 and MEMWBFlush=1, and go to MEM_WAIT.
REQ-023 SHALL, on BranchTaken without MW, drive the normal outputs with IFIDFlush=1 and remain in RUN; a simultaneous LU is discarded.
REQ-024 SHALL, on LU alone, drive PCWrite=0, IFIDEn=0 and IDEXFlush=1 with the remaining enables at 1, and go to LU_STALL.
REQ-025 SHALL, in LU_STALL, ignore LU and evaluate only MW and BranchTaken with RUN rules, then return to RUN unless MW is active; the stall is therefore exactly one cycle.
REQ-026 SHALL, in MEM_WAIT while MemReady=0, hold the MW outputs regardless of BranchTaken and LU.
REQ-027 SHALL, in MEM_WAIT when MemReady=1, apply the full RUN evaluation with MW forced to 0, and take the next state accordingly.
REQ-028 SHALL count consecutive MEM_WAIT cycles in an internal wait counter, cleared on leaving MEM_WAIT.
REQ-029 SHALL set MemTimeout to 1 when the wait counter reaches MEM_TIMEOUT and hold it until reset, while the FSM keeps waiting.
REQ-030 SHALL increment StallCount in each cycle where PCWrite=0, saturating at all-ones.

Reset
REQ-031 SHALL, on a clock edge with rst=1, set State=RUN, StallCount=0, the wait counter to 0 and MemTimeout=0, including mid-stall or mid-wait.
REQ-032 SHALL, while rst=1, force the normal outputs regardless of the other inputs.

Verification
REQ-033 SHALL cover: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle with PCWrite=0, IFIDEn=0, IDEXFlush=1; next cycle normal; StallCount=1.
REQ-034 SHALL cover: IDEX_Rt=0 with a matching Rs, and IDEX_Rt=9 matching IFID_Rt with IFID_UsesRt=0 -> no stall in either case.
REQ-035 SHALL cover: MemReq=1 with MemReady=0 for 3 cycles then 1 -> 3 frozen cycles with MEMWBFlush=1, release on cycle 4, StallCount=3.
REQ-036 SHALL cover: BranchTaken=1 together with LU -> IFIDFlush=1, PCWrite=1, IDEXFlush=0, State stays RUN.
REQ-037 SHALL cover: MEM_TIMEOUT=4 with MemReady held 0 -> MemTimeout=1 after the 4th wait cycle, still 1 after MemReady returns, cleared only by rst.
REQ-038 SHALL cover: rst=1 during MEM_WAIT -> normal outputs while reset, then State=RUN, StallCount=0 and MemTimeout=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy stall/flush controller for load-use, taken-branch and memory-wait hazards.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDEn,
  output logic             IDEXEn,
  output logic             EXMEMEn,
  output logic             MEMWBEn,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBFlush,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout,
  output logic [1:0]       State
);
  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [1:0] RUN = 2'b00, LU_STALL = 2'b01, MEM_WAIT = 2'b10;
  logic [1:0] state_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic lu, mw, br, stall;
  always_comb begin
    lu = IDEX_MemRead && IDEX_Rt != 5'd0 && (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
    // while waiting, only MemReady matters; on release MW is treated as inactive
    mw = !rst && (State == MEM_WAIT ? !MemReady : MemReq && !MemReady);
    br = !rst && !mw && BranchTaken;
    stall = !rst && !mw && !br && lu && State != LU_STALL;
    PCWrite = !mw && !stall;
    IFIDEn = !mw && !stall;
    IDEXEn = !mw;
    EXMEMEn = !mw;
    MEMWBEn = 1'b1;
    IFIDFlush = br;
    IDEXFlush = stall;
    MEMWBFlush = mw;
    state_d = mw ? MEM_WAIT : stall ? LU_STALL : RUN;
    wcnt_d = State != MEM_WAIT ? '0 : wcnt == WW'(MEM_TIMEOUT) ? wcnt : wcnt + WW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      State <= RUN;
      wcnt <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
    end else begin
      State <= state_d;
      wcnt <= wcnt_d;
      MemTimeout <= MemTimeout || wcnt_d == WW'(MEM_TIMEOUT);
      if (!PCWrite && !(&StallCount)) StallCount <= StallCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus random traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 4, TO = 4;
  logic clk = 0, rst = 1;
  logic IDEX_MemRead = 0, IFID_UsesRt = 0, BranchTaken = 0, MemReq = 0, MemReady = 0;
  logic [4:0] IDEX_Rt = 0, IFID_Rs = 0, IFID_Rt = 0;
  logic PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn, IFIDFlush, IDEXFlush, MEMWBFlush, MemTimeout;
  logic [CW-1:0] StallCount;
  logic [1:0] State;
  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs),
    .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .BranchTaken(BranchTaken), .MemReq(MemReq),
    .MemReady(MemReady), .PCWrite(PCWrite), .IFIDEn(IFIDEn), .IDEXEn(IDEXEn), .EXMEMEn(EXMEMEn),
    .MEMWBEn(MEMWBEn), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MEMWBFlush(MEMWBFlush),
    .StallCount(StallCount), .MemTimeout(MemTimeout), .State(State)
  );
  always #5 clk = ~clk;
  wire [7:0] outs = {PCWrite, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn, IFIDFlush, IDEXFlush, MEMWBFlush};
  localparam logic [7:0] NORMAL = 8'b11111000, FROZEN = 8'b00001001, LUST = 8'b00111010, BRFL = 8'b11111100;
  int checks = 0, errors = 0;
  bit run = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask
  // model: memory-wait flag, "just stalled for a load" flag, wait run length, timeout, stall total
  bit waiting = 0, after_lu = 0, m_to = 0;
  int wait_len = 0, m_cnt = 0;
  bit lu_raw, frozen, do_br, do_lu;
  logic [7:0] exp_outs;
  always @(negedge clk) if (run) begin
    lu_raw = IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
    frozen = !rst && (waiting ? !MemReady : MemReq && !MemReady);
    do_br = !rst && !frozen && BranchTaken;
    do_lu = !rst && !frozen && !BranchTaken && lu_raw && !after_lu;
    exp_outs = frozen ? FROZEN : do_lu ? LUST : do_br ? BRFL : NORMAL;
    chk("outputs", 32'(outs), 32'(exp_outs));
    chk("State", 32'(State), waiting ? 2 : after_lu ? 1 : 0);
    chk("StallCount", 32'(StallCount), m_cnt);
    chk("MemTimeout", 32'(MemTimeout), 32'(m_to));
    if (rst) begin
      waiting = 0; after_lu = 0; wait_len = 0; m_to = 0; m_cnt = 0;
    end else begin
      wait_len = waiting ? wait_len + 1 : 0;
      if (wait_len >= TO) m_to = 1;
      if ((frozen || do_lu) && m_cnt < (1 << CW) - 1) m_cnt++;
      waiting = frozen;
      after_lu = do_lu;
    end
  end
  task automatic step(input bit r, input bit mrd, input logic [4:0] xrt, input logic [4:0] rs,
                      input logic [4:0] rt, input bit uses, input bit bt, input bit mq, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; IDEX_MemRead = mrd; IDEX_Rt = xrt; IFID_Rs = rs; IFID_Rt = rt;
    IFID_UsesRt = uses; BranchTaken = bt; MemReq = mq; MemReady = rdy;
    #2;
  endtask
  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction
  initial begin
    @(posedge clk);
    run = 1;
    step(1, 1, 8, 8, 0, 0, 1, 1, 0);
    chk("reset forces normal", 32'(outs), 32'(NORMAL));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset State", 32'(State), 0);
    chk("reset StallCount", 32'(StallCount), 0);
    chk("reset MemTimeout", 32'(MemTimeout), 0);
    step(0, 1, 8, 8, 0, 0, 0, 0, 1);
    chk("lu stall", 32'(outs), 32'(LUST));
    step(0, 1, 8, 8, 0, 0, 0, 0, 1);
    chk("lu stall state", 32'(State), 1);
    chk("lu one cycle", 32'(outs), 32'(NORMAL));
    chk("lu count", 32'(StallCount), 1);
    step(0, 1, 0, 0, 0, 1, 0, 0, 1);
    chk("rt zero no stall", 32'(outs), 32'(NORMAL));
    step(0, 1, 9, 1, 9, 0, 0, 0, 1);
    chk("rt unused no stall", 32'(outs), 32'(NORMAL));
    step(0, 1, 9, 1, 9, 0, 1, 0, 1);
    step(0, 1, 8, 8, 8, 1, 1, 0, 1);
    chk("branch beats lu", 32'(outs), 32'(BRFL));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("branch stays run", 32'(State), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("mw first", 32'(outs), 32'(FROZEN));
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("mw hold over branch", 32'(outs), 32'(FROZEN));
    step(0, 1, 8, 8, 0, 0, 0, 0, 0);
    chk("mw hold without req", 32'(outs), 32'(FROZEN));
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("mw release", 32'(outs), 32'(NORMAL));
    chk("mw release state", 32'(State), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mw count", 32'(StallCount), 4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 4) chk("timeout not yet", 32'(MemTimeout), 0);
    end
    chk("timeout set", 32'(MemTimeout), 1);
    chk("timeout keeps waiting", 32'(State), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("timeout sticky", 32'(MemTimeout), 1);
    chk("count before sat", 32'(StallCount), 10);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("count saturates", 32'(StallCount), 15);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("reset in wait outputs", 32'(outs), 32'(NORMAL));
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("after reset State", 32'(State), 0);
    chk("after reset count", 32'(StallCount), 0);
    chk("after reset timeout", 32'(MemTimeout), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, pick(), pick(), pick(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
